// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline round-robin arbiter.
package pipe_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width helper that never returns 0, so single-value fields stay 1 bit wide.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_pick.sv
// Round-robin picker: rotate the request vector to start at i_start, take the
// lowest set bit, then map that offset back to a requester index.
module pipe_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_any,
  output logic [IW-1:0] o_sel
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;

  // Modular add that also works for non-power-of-two N.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] s, input int k);
    int t;
    t = int'(s) + k;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int k = 0; k < N; k++) w_rot[k] = i_req[wrap(i_start, k)];
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = IW'(k);
    o_any = |i_req;
    o_sel = wrap(i_start, int'(w_off));
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one registered pipeline stage
// that honours downstream stall and a synchronous flush.
module pipe_rr_arbiter
  import pipe_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int SRC_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = clog2w(MAX_BURST + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_stall,
  input  logic                      i_stall,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  output logic [SRC_W-1:0]          o_src,
  output logic [CNT_W-1:0]          o_burst_cnt
);

  arb_state_e                       r_state;
  logic [SRC_W-1:0]                 r_ptr, r_cur, r_src;
  logic [CNT_W-1:0]                 r_cnt;
  logic [DATA_W-1:0]                r_data;
  logic                             r_valid;

  logic                             w_ce, w_keep, w_any;
  logic [SRC_W-1:0]                 w_start, w_pick, w_sel;
  logic [NUM_REQ-1:0][DATA_W-1:0]   w_lane_data;

  function automatic logic [SRC_W-1:0] inc_wrap(input logic [SRC_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign w_lane_data = i_req_data;
  assign w_ce        = ~r_valid | ~i_stall;
  assign w_keep      = (r_state == ARB_BURST) & i_req_valid[r_cur] &
                       (r_cnt < CNT_W'(MAX_BURST));
  // An expired or dropped owner searches from its successor, so it only wins
  // again if nobody else is asking.
  assign w_start     = (r_state == ARB_BURST) ? inc_wrap(r_cur) : r_ptr;
  assign w_sel       = w_keep ? r_cur : w_pick;

  pipe_rr_pick #(
    .N  (NUM_REQ),
    .IW (SRC_W)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_start (w_start),
    .o_any   (w_any),
    .o_sel   (w_pick)
  );

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_stall
    assign o_req_stall[r] = ~(w_ce & ~i_flush & w_any & (w_sel == SRC_W'(r)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_ptr   <= inc_wrap(r_cur);
    end else if (w_ce) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_lane_data[w_sel];
        r_src   <= w_sel;
        if (w_keep) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cur   <= w_sel;
          r_cnt   <= CNT_W'(1);
          r_state <= ARB_BURST;
        end
      end else begin
        r_valid <= 1'b0;
        r_state <= ARB_IDLE;
        r_cnt   <= '0;
        if (r_state == ARB_BURST) r_ptr <= inc_wrap(r_cur);
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_src       = r_src;
  assign o_burst_cnt = r_cnt;

endmodule
